// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: a DEPTH-entry circular FIFO with valid/ready on both sides,
// plus stall (freeze output side) and flush (drop all buffered entries).
module pipe_stage_buf #(
   parameter int unsigned       WIDTH          = 64,
   parameter int unsigned       DEPTH          = 2,
   parameter logic [WIDTH-1:0]  BUBBLE         = '0,
   parameter bit                CLEAR_ON_EMPTY = 1'b1,
   localparam int unsigned      CW             = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             stall,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   // Handshake: a beat transfers on a rising edge only when valid and ready are both 1
   // in the preceding cycle; valid never waits on ready, and the payload is held while
   // valid=1 and ready=0.
   localparam int unsigned    PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0]  LAST_PTR = PW'(DEPTH - 1);
   localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             push;
   logic             pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   assign full      = (count == FULL_CNT);
   assign empty     = (count == '0);
   assign out_valid = !empty && !stall && !flush;
   assign pop       = out_valid && out_ready;
   // A full buffer still accepts when the head leaves in the same cycle.
   assign in_ready  = reset && !flush && (!full || pop);
   assign push      = in_valid && in_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Payload storage is never reset; occupancy alone decides what is valid.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_comb begin
      out_data = mem[rd_ptr];
      if (CLEAR_ON_EMPTY && !out_valid) out_data = BUBBLE;
   end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed vectors on a DEPTH=2 and a DEPTH=3 instance,
// with per-instance expected-data queues drained by output monitors.
module tb_pipe_stage_buf;

   logic clock;
   logic reset;

   // DEPTH=2 instance
   logic       a_flush, a_stall, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [7:0] a_in_data, a_out_data;
   logic [1:0] a_count;
   logic       a_full, a_empty;

   // DEPTH=3 instance
   logic       b_flush, b_stall, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [7:0] b_in_data, b_out_data;
   logic [1:0] b_count;
   logic       b_full, b_empty;

   logic [7:0] a_exp_q[$];
   logic [7:0] b_exp_q[$];
   int total;
   int bad;
   int a_pops;
   int b_pops;

   pipe_stage_buf #(.WIDTH(8), .DEPTH(2)) u_a (
      .clock(clock), .reset(reset), .flush(a_flush), .stall(a_stall),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .count(a_count), .full(a_full), .empty(a_empty)
   );

   pipe_stage_buf #(.WIDTH(8), .DEPTH(3)) u_b (
      .clock(clock), .reset(reset), .flush(b_flush), .stall(b_stall),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .count(b_count), .full(b_full), .empty(b_empty)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // inputs change 2 time units after the rising edge; checks happen 1 unit later
   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   // drive one beat on instance A; the bench's own expectation of in_ready decides acceptance
   task automatic a_drive(input logic [7:0] d, input logic exp_ready, input string name);
      a_in_valid = 1'b1;
      a_in_data  = d;
      #1;
      check(name, a_in_ready, exp_ready);
      if (exp_ready) a_exp_q.push_back(d);
      tick();
      a_in_valid = 1'b0;
   endtask

   task automatic b_drive(input logic [7:0] d, input logic exp_ready, input string name);
      b_in_valid = 1'b1;
      b_in_data  = d;
      #1;
      check(name, b_in_ready, exp_ready);
      if (exp_ready) b_exp_q.push_back(d);
      tick();
      b_in_valid = 1'b0;
   endtask

   // scoreboard monitors: compare whenever a pop is about to happen
   always @(negedge clock) begin
      if (reset && a_out_valid && a_out_ready) begin
         a_pops++;
         if (a_exp_q.size() == 0) check("a_unexpected_pop", a_out_data, 32'hdead);
         else check("a_out_data", a_out_data, a_exp_q.pop_front());
      end
   end

   always @(negedge clock) begin
      if (reset && b_out_valid && b_out_ready) begin
         b_pops++;
         if (b_exp_q.size() == 0) check("b_unexpected_pop", b_out_data, 32'hdead);
         else check("b_out_data", b_out_data, b_exp_q.pop_front());
      end
   end

   initial begin
      total = 0; bad = 0; a_pops = 0; b_pops = 0;
      reset = 1'b0;
      a_flush = 0; a_stall = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
      b_flush = 0; b_stall = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;

      // reset state
      #3;
      check("rst_in_ready", a_in_ready, 0);
      check("rst_out_valid", a_out_valid, 0);
      check("rst_empty", a_empty, 1);
      check("rst_full", a_full, 0);
      check("rst_count", a_count, 0);
      check("rst_out_data", a_out_data, 8'h00);
      #9 reset = 1'b1;
      tick();
      check("post_rst_in_ready", a_in_ready, 1);

      // fill to full with downstream blocked
      a_drive(8'h11, 1, "fill0_ready");
      check("one_entry_valid", a_out_valid, 1);
      check("one_entry_data", a_out_data, 8'h11);
      a_drive(8'h22, 1, "fill1_ready");
      check("full_flag", a_full, 1);
      check("full_count", a_count, 2);
      check("full_in_ready", a_in_ready, 0);
      check("full_head", a_out_data, 8'h11);

      // full with simultaneous pop and push
      a_out_ready = 1'b1;
      a_drive(8'h33, 1, "full_pop_push_ready");
      check("pop_push_count", a_count, 2);
      tick();
      tick();
      check("drained_empty", a_empty, 1);
      check("drained_count", a_count, 0);
      check("drained_bubble", a_out_data, 8'h00);
      check("drained_pops", a_pops, 3);

      // stall holds a single entry
      a_out_ready = 1'b0;
      a_drive(8'h11, 1, "stall_fill_ready");
      a_stall = 1'b1;
      a_out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_out_valid", a_out_valid, 0);
         check("stall_count", a_count, 1);
         tick();
      end
      a_stall = 1'b0;
      #1;
      check("unstall_valid", a_out_valid, 1);
      tick();
      check("unstall_count", a_count, 0);
      check("unstall_pops", a_pops, 4);

      // flush beats a concurrent push
      a_out_ready = 1'b0;
      a_drive(8'h44, 1, "pre_flush0_ready");
      a_drive(8'h55, 1, "pre_flush1_ready");
      a_flush = 1'b1;
      a_in_valid = 1'b1;
      a_in_data = 8'h66;
      #1;
      check("flush_in_ready", a_in_ready, 0);
      check("flush_out_valid", a_out_valid, 0);
      a_exp_q.delete();
      tick();
      a_flush = 1'b0;
      a_in_valid = 1'b0;
      #1;
      check("post_flush_count", a_count, 0);
      check("post_flush_empty", a_empty, 1);
      check("post_flush_data", a_out_data, 8'h00);

      // asynchronous reset in the middle of a cycle
      a_drive(8'h77, 1, "pre_rst0_ready");
      a_drive(8'h88, 1, "pre_rst1_ready");
      check("pre_rst_count", a_count, 2);
      reset = 1'b0;
      a_exp_q.delete();
      #1;
      check("async_rst_out_valid", a_out_valid, 0);
      check("async_rst_count", a_count, 0);
      check("async_rst_in_ready", a_in_ready, 0);
      check("async_rst_data", a_out_data, 8'h00);
      #4 reset = 1'b1;
      tick();
      check("rerst_count", a_count, 0);
      check("rerst_in_ready", a_in_ready, 1);
      a_out_ready = 1'b1;
      a_drive(8'h99, 1, "after_rst_ready");
      tick();
      check("after_rst_pops", a_pops, 5);

      // DEPTH=3: fill, then stream four beats through a full buffer, then drain
      b_drive(8'h01, 1, "b_push1");
      b_drive(8'h02, 1, "b_push2");
      b_drive(8'h03, 1, "b_push3");
      check("b_full", b_full, 1);
      check("b_full_in_ready", b_in_ready, 0);
      b_out_ready = 1'b1;
      b_drive(8'h04, 1, "b_push4");
      b_drive(8'h05, 1, "b_push5");
      b_drive(8'h06, 1, "b_push6");
      b_drive(8'h07, 1, "b_push7");
      check("b_stream_count", b_count, 3);
      tick();
      tick();
      tick();
      check("b_empty", b_empty, 1);
      check("b_pops", b_pops, 7);
      check("a_queue_left", a_exp_q.size(), 0);
      check("b_queue_left", b_exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter WIDTH, default 64: payload width in bits; legal values are 1 and above.
REQ-002 Parameter DEPTH, default 2: number of buffer entries; legal values are 1 and above; power of two is not required.
REQ-003 Parameter BUBBLE, default all zeros (WIDTH bits): payload value driven when no valid entry is presented.
REQ-004 Parameter CLEAR_ON_EMPTY, default 1: 1 drives BUBBLE on out_data when out_valid=0; 0 leaves out_data unspecified in that case.
REQ-005 clock  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset; asserted at 0.
REQ-007 flush  input  1  synchronous kill of all buffered entries.
REQ-008 stall  input  1  freezes the output side; nothing is presented or popped.
REQ-009 in_valid  input  1  upstream offers in_data.
REQ-010 in_ready  output  1  stage accepts in_data this cycle.
REQ-011 in_data  input  WIDTH  upstream payload.
REQ-012 out_valid  output  1  out_data holds a valid entry.
REQ-013 out_ready  input  1  downstream accepts out_data.
REQ-014 out_data  output  WIDTH  oldest buffered payload.
REQ-015 count  output  CW=$clog2(DEPTH+1)  current occupancy, 0..DEPTH.
REQ-016 full / empty  output  1 each  full=(count==DEPTH), empty=(count==0).

Function
REQ-017 Storage shall be a circular buffer of DEPTH entries with a read pointer, a write pointer and count; FIFO order shall always be preserved.
REQ-018 Pointer wrap: each pointer shall advance to 0 after DEPTH-1, for any DEPTH including non-power-of-two values.
REQ-019 out_valid = !empty & !stall & !flush.
REQ-020 pop = out_valid & out_ready.
REQ-021 in_ready = !flush & (!full | pop); the full-with-simultaneous-pop path is combinational from out_ready and stall.
REQ-022 push = in_valid & in_ready.
REQ-023 On push, in_data shall be written at the write pointer and the write pointer advanced; on pop, the read pointer shall be advanced.
REQ-024 count shall update as count + push - pop; simultaneous push and pop leaves count unchanged, including at full and at DEPTH=1.
REQ-025 Latency: a payload pushed at edge N into an empty, unstalled buffer shall appear on out_data with out_valid=1 immediately after edge N; there is no bypass from in_data to out_data in the same cycle.
REQ-026 out_data shall equal the entry at the read pointer when out_valid=1; otherwise it shall be BUBBLE when CLEAR_ON_EMPTY=1.
REQ-027 stall=1: no pop occurs; out_valid=0; push continues while not full; contents are held.
REQ-028 flush=1: at the next edge, count=0 and both pointers=0; flush has priority over push, pop and stall; in_ready=0 and out_valid=0 during the flush cycle.
REQ-029 Overflow and underflow are impossible by construction: push only when in_ready=1, pop only when out_valid=1; no error state exists.
REQ-030 At DEPTH=1 the block shall behave as a single valid/ready pipeline register with in_ready = !full | pop.

Reset
REQ-031 reset=0 shall immediately and asynchronously clear count, both pointers and all valid state; out_valid=0, empty=1, full=0, and out_data=BUBBLE.
REQ-032 While reset=0, in_ready shall be 0; after release, in_ready=1 in the first cycle with flush=0.
REQ-033 Reset asserted mid-transfer shall discard all entries without requiring a clock edge; payload RAM contents need not be cleared.

Verification
REQ-034 WIDTH=8, DEPTH=2: push 0x11, 0x22 with out_ready=0 -> full=1, count=2, in_ready=0, out_data=0x11.
REQ-035 Full buffer, out_ready=1, in_valid=1 with 0x33 -> pop 0x11 and push 0x33 on the same edge; count stays 2; next output order is 0x22, then 0x33.
REQ-036 count=1, stall=1, out_ready=1 for 3 cycles -> out_valid=0, no pop, count=1; stall=0 -> 0x11 presented and popped.
REQ-037 count=2, flush=1 together with in_valid=1 -> in_ready=0; next cycle count=0, empty=1, out_data=0x00.
REQ-038 DEPTH=3: 7 pushes interleaved with pops -> pointers wrap 2->0, and outputs match the input sequence exactly.
REQ-039 reset pulsed low mid-cycle with count=2 -> out_valid drops to 0 before the next edge; count=0 after release.
